// File: rtl/dice_roll_display.sv
// Dice roll front-end: debounced button gesture, roll/settle/show FSM,
// pip-face decode, saturating capture counter and sticky illegal-value flag.
module dice_roll_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES   = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Button,
  input  logic [2:0]       DiceValue,
  output logic [6:0]       Pips,
  output logic [2:0]       Result,
  output logic             ResultValid,
  output logic [CNT_W-1:0] RollCount,
  output logic             Error
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLLING,
    S_SETTLE,
    S_SHOW,
    S_ERR
  } state_t;

  function automatic logic [6:0] decode(input logic [2:0] v);
    case (v)
      3'd1:    decode = 7'b0001000;
      3'd2:    decode = 7'b1000001;
      3'd3:    decode = 7'b1001001;
      3'd4:    decode = 7'b1100011;
      3'd5:    decode = 7'b1101011;
      3'd6:    decode = 7'b1110111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  logic            sync1_q, btn_s_q, db_level_q, rise_q, fall_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q    <= 1'b0;
      btn_s_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sync1_q <= Button;
      btn_s_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (btn_s_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_level_q <= ~db_level_q;
        db_cnt_q   <= '0;
        rise_q     <= ~db_level_q;
        fall_q     <= db_level_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  state_t           state_q, state_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic [2:0]       result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;
  logic [6:0]       pips_q, pips_d;
  logic             illegal;

  assign illegal = (DiceValue == 3'd0) || (DiceValue == 3'd7);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    result_d = result_q;
    count_d  = count_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE:    if (rise_q) state_d = S_ROLLING;
      S_ROLLING: begin
        // Illegal input wins over a release in the same cycle.
        if (illegal) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else if (fall_q) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        if (illegal) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else if (settle_q == ST_LAST) begin
          result_d = DiceValue;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          state_d = S_SHOW;
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end
      S_SHOW:  if (rise_q) state_d = S_ROLLING;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Pips are registered off the next state so the face matches the state it enters.
    case (state_d)
      S_ROLLING, S_SETTLE: pips_d = decode(DiceValue);
      S_SHOW:              pips_d = decode(result_d);
      S_ERR:               pips_d = 7'h7F;
      default:             pips_d = 7'h00;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      result_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      pips_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      result_q <= result_d;
      count_q  <= count_d;
      error_q  <= error_d;
      pips_q   <= pips_d;
    end
  end

  assign Pips        = pips_q;
  assign Result      = result_q;
  assign ResultValid = (state_q == S_SHOW);
  assign RollCount   = count_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_dice_roll_display.sv
// Directed bench for dice_roll_display with default parameters (debounce 16, settle 8, 8-bit count).
module tb_dice_roll_display;

  localparam int unsigned DB  = 16;
  localparam int unsigned ST  = 8;
  localparam int unsigned PRESS_LAT   = DB + 3;      // button edge to ROLLING
  localparam int unsigned RELEASE_LAT = DB + 3 + ST; // button release to SHOW

  logic       Clock, Reset, Button;
  logic [2:0] DiceValue;
  logic [6:0] Pips;
  logic [2:0] Result;
  logic       ResultValid;
  logic [7:0] RollCount;
  logic       Error;

  int checks = 0;
  int errors = 0;

  dice_roll_display #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Button(Button), .DiceValue(DiceValue),
    .Pips(Pips), .Result(Result), .ResultValid(ResultValid),
    .RollCount(RollCount), .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    Button = 1'b0;
    tick(2);
    Reset = 1'b0;
    check({tag, "_pips"}, 32'(Pips), 32'h0);
    check({tag, "_res"},  32'(Result), 32'h0);
    check({tag, "_rv"},   32'(ResultValid), 32'h0);
    check({tag, "_cnt"},  32'(RollCount), 32'h0);
    check({tag, "_err"},  32'(Error), 32'h0);
  endtask

  task automatic roll(input logic [2:0] v);
    DiceValue = v;
    Button = 1'b1;
    tick(PRESS_LAT);
    Button = 1'b0;
    tick(RELEASE_LAT);
  endtask

  initial begin
    Reset = 1'b1;
    Button = 1'b0;
    DiceValue = 3'd1;
    do_reset("rst_init");
    tick(1);
    check("idle_pips", 32'(Pips), 32'h0);

    // Short glitches never reach the debounced level.
    for (int w = 1; w <= int'(DB) - 2; w++) begin
      Button = 1'b1;
      tick(w);
      Button = 1'b0;
      tick(20);
      check($sformatf("glitch%0d", w), {24'h0, ResultValid, Pips}, 32'h0);
    end

    // Long press, value 3.
    DiceValue = 3'd3;
    Button = 1'b1;
    tick(100);
    check("roll_pips3", 32'(Pips), 32'b1001001);
    DiceValue = 3'd5;
    check("roll_lag", 32'(Pips), 32'b1001001);
    tick(1);
    check("roll_pips5", 32'(Pips), 32'b1101011);
    DiceValue = 3'd3;
    Button = 1'b0;
    tick(RELEASE_LAT - 1);
    check("settle_rv", 32'(ResultValid), 32'h0);
    tick(1);
    check("show_rv", 32'(ResultValid), 32'h1);
    check("show_res", 32'(Result), 32'h3);
    check("show_pips", 32'(Pips), 32'b1001001);
    check("show_cnt", 32'(RollCount), 32'h1);

    // Re-press from SHOW with Result 6.
    roll(3'd6);
    check("r6_res", 32'(Result), 32'h6);
    check("r6_cnt", 32'(RollCount), 32'h2);
    DiceValue = 3'd2;
    Button = 1'b1;
    tick(PRESS_LAT - 1);
    check("r6_still_show", 32'(ResultValid), 32'h1);
    tick(1);
    check("r6_rv_drop", 32'(ResultValid), 32'h0);
    check("r6_res_hold", 32'(Result), 32'h6);
    check("r6_pips_roll", 32'(Pips), 32'b1000001);
    DiceValue = 3'd4;
    Button = 1'b0;
    tick(RELEASE_LAT);
    check("r4_res", 32'(Result), 32'h4);
    check("r4_cnt", 32'(RollCount), 32'h3);
    check("r4_pips", 32'(Pips), 32'b1100011);

    // Illegal value while rolling.
    DiceValue = 3'd2;
    Button = 1'b1;
    tick(PRESS_LAT);
    DiceValue = 3'd0;
    tick(1);
    check("err_flag", 32'(Error), 32'h1);
    check("err_pips", 32'(Pips), 32'h7F);
    check("err_rv", 32'(ResultValid), 32'h0);
    DiceValue = 3'd3;
    Button = 1'b0; tick(30);
    Button = 1'b1; tick(30);
    Button = 1'b0; tick(30);
    check("err_sticky", 32'(Error), 32'h1);
    check("err_pips_hold", 32'(Pips), 32'h7F);
    check("err_res_hold", 32'(Result), 32'h4);
    check("err_cnt_hold", 32'(RollCount), 32'h3);
    do_reset("rst_err");

    // Reset while rolling and while settling.
    Button = 1'b1;
    tick(PRESS_LAT + 5);
    do_reset("rst_roll");
    DiceValue = 3'd5;
    Button = 1'b1;
    tick(PRESS_LAT);
    Button = 1'b0;
    tick(RELEASE_LAT - 2);
    do_reset("rst_settle");
    tick(5);
    check("rst_settle_nocap", {24'h0, ResultValid, Result, RollCount[3:0]}, 32'h0);

    // Reset in SHOW.
    roll(3'd2);
    check("pre_rst_show", 32'(ResultValid), 32'h1);
    do_reset("rst_show");

    // Illegal value coinciding with the release edge.
    DiceValue = 3'd2;
    Button = 1'b1;
    tick(PRESS_LAT);
    Button = 1'b0;
    tick(DB + 2);
    DiceValue = 3'd7;
    tick(1);
    check("prio_fall_err", 32'(Error), 32'h1);
    check("prio_fall_pips", 32'(Pips), 32'h7F);
    do_reset("rst_pf");

    // Illegal value on the capture cycle.
    DiceValue = 3'd5;
    Button = 1'b1;
    tick(PRESS_LAT);
    Button = 1'b0;
    tick(RELEASE_LAT - 1);
    DiceValue = 3'd0;
    tick(1);
    check("prio_cap_err", 32'(Error), 32'h1);
    check("prio_cap_cnt", 32'(RollCount), 32'h0);
    check("prio_cap_res", 32'(Result), 32'h0);
    check("prio_cap_rv", 32'(ResultValid), 32'h0);
    do_reset("rst_pc");

    // Illegal values are ignored in IDLE and SHOW.
    DiceValue = 3'd0;
    tick(5);
    check("idle_noerr", 32'(Error), 32'h0);
    roll(3'd1);
    DiceValue = 3'd7;
    tick(5);
    check("show_noerr", 32'(Error), 32'h0);
    check("show_rv_keep", 32'(ResultValid), 32'h1);
    check("show_pips1", 32'(Pips), 32'b0001000);

    // Count saturation.
    do_reset("rst_sat");
    for (int i = 1; i <= 256; i++) begin
      logic [2:0] v;
      v = 3'((i % 6) + 1);
      roll(v);
      if (i == 1)   check("sat_cnt1", 32'(RollCount), 32'd1);
      if (i == 255) check("sat_cnt255", 32'(RollCount), 32'd255);
      if (i == 256) begin
        check("sat_cnt256", 32'(RollCount), 32'd255);
        check("sat_res256", 32'(Result), 32'(v));
        check("sat_rv256", 32'(ResultValid), 32'h1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
